dp_ram_sync_clr: RTL



---
 rtl/dp_ram_sync_clr.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dp_ram_sync_clr.sv
// Simple dual-port RAM (A writes, B reads) with selectable read latency,
// defined same-address collision policy and a built-in clear sweep.
module dp_ram_sync_clr #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned RD_LATENCY     = 1,
    parameter bit          WRITE_FIRST    = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Clear,
    output logic                  Busy,
    input  logic                  WrA,
    input  logic [ADDR_WIDTH-1:0] AddressA,
    input  logic [DATA_WIDTH-1:0] DataInA,
    output logic                  WrDropped,
    input  logic                  RdB,
    input  logic [ADDR_WIDTH-1:0] AddressB,
    output logic [DATA_WIDTH-1:0] QB,
    output logic                  QBValid
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                  state_q;
    logic                    busy_q;
    logic                    wr_dropped_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;

    logic                    idle;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    rd_acc;
    logic                    collide;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_raw_q;
    logic                    vld1_q;
    logic                    byp_sel_q;
    logic [DATA_WIDTH-1:0]   byp_data_q;
    logic [DATA_WIDTH-1:0]   d1;

    // Single write port: user port A in IDLE, sweep counter in CLEAR.
    always_comb begin
        idle    = (state_q == ST_IDLE);
        wr_en   = 1'b0;
        wr_addr = AddressA;
        wr_data = DataInA;
        if (idle) begin
            wr_en = WrA;
        end else begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = CLEAR_VALUE;
        end
        rd_acc  = idle && RdB;
        collide = WRITE_FIRST && idle && WrA && (AddressA == AddressB);
    end

    // Clear sequencer and write-drop flag.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            busy_q       <= CLEAR_ON_RESET;
            cnt_q        <= '0;
            wr_dropped_q <= 1'b0;
        end else begin
            wr_dropped_q <= (state_q == ST_CLEAR) && WrA;
            case (state_q)
                ST_IDLE: begin
                    if (Clear) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Block RAM core: read-first array with enabled output register, no reset.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_acc) begin
            rd_raw_q <= mem_q[AddressB];
        end
    end

    // Bypass select resets to 1 with zero data so QB reads 0 straight out of reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vld1_q     <= 1'b0;
            byp_sel_q  <= 1'b1;
            byp_data_q <= '0;
        end else begin
            vld1_q <= rd_acc;
            if (rd_acc) begin
                byp_sel_q  <= collide;
                byp_data_q <= DataInA;
            end
        end
    end

    assign d1 = byp_sel_q ? byp_data_q : rd_raw_q;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] qb_q;
            logic                  qbv_q;

            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    qb_q  <= '0;
                    qbv_q <= 1'b0;
                end else begin
                    qbv_q <= vld1_q;
                    if (vld1_q) begin
                        qb_q <= d1;
                    end
                end
            end

            assign QB      = qb_q;
            assign QBValid = qbv_q;
        end else begin : g_lat1
            assign QB      = d1;
            assign QBValid = vld1_q;
        end
    endgenerate

    assign Busy      = busy_q;
    assign WrDropped = wr_dropped_q;

endmodule
